dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder at the far end of the M-stage load/store interface of the five-stage MIPS pipeline. It accepts one load or store request at a time from the memory stage and services it after a configurable number of wait states. Its datapath covers byte and halfword lane steering, load sign/zero extension and alignment/range checking. While a request is outstanding, and during the post-reset RAM clear sweep, it asserts a stall to the hazard unit.

## Interface
Parameters:
- DEPTH_WORDS, 2048: RAM depth in 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 1: wait states between acceptance and response; range 0..15.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  one clock; reset is synchronous and active-high.
- req_valid  in  1  M-stage holds a load or store; request fields are held stable while Stall_Mem=1.
- MemWrite  in  2  00 no store, 01 sw, 10 sh, 11 sb.
- LdType  in  3  000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; others are treated as lw. Used only when MemWrite=00.
- Addr  in  32  byte address (ALUOut_M).
- WData  in  32  store data, after M-stage forwarding.
- RData  out  32  load result, valid when Ready=1.
- Ready  out  1  one-cycle response pulse.
- AddrErr  out  1  qualified by Ready; access was misaligned or out of range.
- Stall_Mem  out  1  freezes F/D/E/M; the hazard unit ORs it into its stalls.

## Operation
- States:
  - INIT: clear sweep; writes zero to index clr_idx, one word per cycle.
  - IDLE
  - BUSY: wait counter running.
  - RESP: response cycle.
- RESET=1: state←INIT, clr_idx←0, wait counter←0, RData←0, Ready←0, AddrErr←0. Any in-flight store is discarded.
- INIT: after writing word DEPTH_WORDS-1, go to IDLE. Takes exactly DEPTH_WORDS cycles. Stall_Mem=1 throughout, regardless of req_valid.
- IDLE with req_valid=1: capture Addr, WData, MemWrite, LdType, then:
  - WAIT_CYCLES=0: go to RESP.
  - otherwise: load the counter with WAIT_CYCLES-1 and go to BUSY.
- BUSY: decrement the counter; at 0, go to RESP.
- RESP: Ready=1. Next state is always IDLE; req_valid is not sampled in RESP.
- Stall_Mem = (state==INIT) | (req_valid & state!=RESP).
- Error check on the captured request:
  - word index Addr[31:2] ≥ DEPTH_WORDS;
  - sw/lw with Addr[1:0]≠0;
  - sh/lh/lhu with Addr[0]≠0.
  - On error: AddrErr=1, RData=0, RAM unchanged.
- Stores: committed at the RESP-cycle edge, little-endian lanes.
  - sb writes WData[7:0] to byte Addr[1:0].
  - sh writes WData[15:0] to half Addr[1].
  - sw writes the full word.
  - Unwritten lanes are preserved (read-modify-write or byte enables).
  - Stores drive RData=0.
- Loads: RData holds the extracted lane.
  - lb/lh sign-extend.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- Outside RESP: RData=0 and AddrErr=0.

## Timing
- Request accepted in cycle t (IDLE, req_valid=1); Ready in cycle t+WAIT_CYCLES+1. The pipeline advances at the end of that cycle.
- Throughput: one access per WAIT_CYCLES+2 cycles. The IDLE acceptance cycle of the next request always follows RESP.
- A store is visible to a load accepted in any later cycle; RAM read happens after the write edge.
- Outputs are registered or state-decoded, except Stall_Mem, which is combinational from req_valid.
- RESET during BUSY/RESP:
  - the state aborts within the same edge;
  - no RAM write for the aborted request;
  - Ready=0 from the next cycle.
- After reset deassertion, the first possible Ready is at cycle DEPTH_WORDS+WAIT_CYCLES+1.

## Test plan
- Reset/clear: DEPTH_WORDS=16. Hold RESET for 2 cycles, then release.
  - Stall_Mem=1 for exactly 16 cycles, Ready=0.
  - Then lw of 0x3C → RData=0x00000000, AddrErr=0.
- Store/load mix, WAIT_CYCLES=1:
  - sw 0x11223344 @0x8; sb 0xAA @0xA; sh 0xBEEF @0x8.
  - lw @0x8 → 0x11AABEEF.
  - lb @0xA → 0xFFFFFFAA; lbu @0xA → 0x000000AA.
  - lh @0x8 → 0xFFFFBEEF; lhu @0xA → 0x000011AA.
  - Each Ready arrives 2 cycles after acceptance.
- Handshake latency sweep: WAIT_CYCLES = 0, 1, 3 with continuous back-to-back requests.
  - Ready exactly WAIT_CYCLES+1 cycles after each acceptance.
  - Stall_Mem falls only in RESP cycles.
  - Accepted requests are never lost or duplicated.
- Errors:
  - sw @0x2 → Ready with AddrErr=1; a following lw @0x0 shows the word unchanged.
  - lh @0x1 → AddrErr=1, RData=0.
  - lw @(DEPTH_WORDS·4) → AddrErr=1.
- Reset mid-store: sw 0xDEADBEEF @0x4 with WAIT_CYCLES=3; assert RESET in the second BUSY cycle.
  - No Ready for that request.
  - After the clear sweep, lw @0x4 → 0x00000000.
- Stall gating: req_valid=0 in IDLE → Stall_Mem=0. Raise req_valid → Stall_Mem=1 in the same cycle.

Source files
------------

// File: rtl/dm_responder_if.sv
// Load/store request bundle between the M stage and the data-memory responder.
// Ports: req_valid/MemWrite/LdType/Addr/WData towards memory; RData/Ready/AddrErr/Stall_Mem back.
// master = M stage (holds request while Stall_Mem=1), slave = dm_responder.
interface dm_responder_if;
    logic        req_valid;
    logic [1:0]  MemWrite;
    logic [2:0]  LdType;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Ready;
    logic        AddrErr;
    logic        Stall_Mem;

    modport master (
        output req_valid, MemWrite, LdType, Addr, WData,
        input  RData, Ready, AddrErr, Stall_Mem
    );

    modport slave (
        input  req_valid, MemWrite, LdType, Addr, WData,
        output RData, Ready, AddrErr, Stall_Mem
    );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one lw/lb/lbu/lh/lhu/sw/sh/sb at a time with lane steering and checks.
// Latency: Ready pulses WAIT_CYCLES+1 cycles after acceptance; a DEPTH_WORDS-cycle clear sweep follows reset.
// Backpressure: Stall_Mem holds the pipeline during the sweep and until the response cycle.
// Ports: CLK, RESET (sync, active-high), bus (dm_responder_if.slave).
module dm_responder #(
    parameter int DEPTH_WORDS = 2048,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    dm_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [3:0]    WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH_WORDS - 1);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [AW-1:0] clr_idx;
    logic [3:0]    wait_cnt;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [1:0]    cap_mw;
    logic [2:0]    cap_ld;
    logic [31:0]   rdata_q;
    logic          err_q;

    function automatic logic access_err(input logic [31:0] a, input logic [1:0] mw,
                                        input logic [2:0] ld);
        logic is_half;
        logic is_byte;
        logic is_word;
        if (mw != 2'b00) begin
            is_half = (mw == 2'b10);
            is_byte = (mw == 2'b11);
        end else begin
            is_half = (ld == 3'b011) || (ld == 3'b100);
            is_byte = (ld == 3'b001) || (ld == 3'b010);
        end
        is_word = !is_half && !is_byte;
        return (|a[31:AW+2]) | (is_word & (a[1:0] != 2'b00)) | (is_half & a[0]);
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [2:0] ld);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (ld)
            3'b001:  return {24'h0, b};
            3'b010:  return {{24{b[7]}}, b};
            3'b011:  return {16'h0, h};
            3'b100:  return {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // The response is computed on the edge entering RESP. With zero wait states that
    // edge is the acceptance edge, so the live bus fields are used; otherwise the
    // captured copy. Any store in flight committed on an earlier edge.
    logic        go_resp;
    logic [31:0] src_addr;
    logic [1:0]  src_mw;
    logic [2:0]  src_ld;
    logic        src_err;
    logic [31:0] src_load;

    always_comb begin
        go_resp  = ((state == ST_IDLE) && bus.req_valid && (WAIT_CYCLES == 0)) ||
                   ((state == ST_BUSY) && (wait_cnt == 4'd0));
        src_addr = (state == ST_IDLE) ? bus.Addr     : cap_addr;
        src_mw   = (state == ST_IDLE) ? bus.MemWrite : cap_mw;
        src_ld   = (state == ST_IDLE) ? bus.LdType   : cap_ld;
        src_err  = access_err(src_addr, src_mw, src_ld);
        src_load = load_extract(mem[src_addr[AW+1:2]], src_addr[1:0], src_ld);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_INIT;
            clr_idx  <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // Response fields live for exactly the RESP cycle.
            rdata_q <= '0;
            err_q   <= 1'b0;
            case (state)
                ST_INIT: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cap_addr  <= bus.Addr;
                        cap_wdata <= bus.WData;
                        cap_mw    <= bus.MemWrite;
                        cap_ld    <= bus.LdType;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (wait_cnt == 4'd0) state <= ST_RESP;
                    else                  wait_cnt <= wait_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
            if (go_resp) begin
                err_q   <= src_err;
                rdata_q <= (src_err || (src_mw != 2'b00)) ? 32'h0 : src_load;
            end
        end
    end

    // Store commit on the edge ending RESP; byte enables keep untouched lanes.
    logic        st_commit;
    logic [3:0]  st_be;
    logic [31:0] st_lane;

    always_comb begin
        st_commit = (state == ST_RESP) && (cap_mw != 2'b00) && !err_q;
        case (cap_mw)
            2'b11: begin
                st_be   = 4'b0001 << cap_addr[1:0];
                st_lane = {4{cap_wdata[7:0]}};
            end
            2'b10: begin
                st_be   = cap_addr[1] ? 4'b1100 : 4'b0011;
                st_lane = {2{cap_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_lane = cap_wdata;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == ST_INIT) begin
                mem[clr_idx] <= 32'h0;
            end else if (st_commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_be[b]) mem[cap_addr[AW+1:2]][8*b +: 8] <= st_lane[8*b +: 8];
                end
            end
        end
    end

    assign bus.RData     = rdata_q;
    assign bus.AddrErr   = err_q;
    assign bus.Ready     = (state == ST_RESP);
    assign bus.Stall_Mem = (state == ST_INIT) | (bus.req_valid & (state != ST_RESP));
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (DEPTH_WORDS=16, WAIT_CYCLES 0/1/3)
// sharing CLK and RESET; each scenario task drives one instance and checks inline.
module tb_dm_responder;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic [2:0]       rv;
    logic [2:0][1:0]  mw;
    logic [2:0][2:0]  ld;
    logic [2:0][31:0] ad;
    logic [2:0][31:0] wd;
    logic [2:0][31:0] rdat;
    logic [2:0]       rdy;
    logic [2:0]       aerr;
    logic [2:0]       stl;

    int total = 0;
    int bad   = 0;
    int pc [3] = '{0, 0, 0};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dm_responder_if bus();
        assign bus.req_valid = rv[g];
        assign bus.MemWrite  = mw[g];
        assign bus.LdType    = ld[g];
        assign bus.Addr      = ad[g];
        assign bus.WData     = wd[g];
        assign rdat[g]       = bus.RData;
        assign rdy[g]        = bus.Ready;
        assign aerr[g]       = bus.AddrErr;
        assign stl[g]        = bus.Stall_Mem;
        dm_responder #(
            .DEPTH_WORDS(16),
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .CLK  (CLK),
            .RESET(RESET),
            .bus  (bus)
        );
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) if (rdy[i] === 1'b1) pc[i] = pc[i] + 1;
    end

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // Called just after a rising edge; the first falling edge seen is the acceptance
    // cycle. lat = cycles from acceptance to Ready (-1 on timeout). stall_bad flags any
    // cycle where Stall_Mem was not the inverse of Ready while the request was held.
    task automatic do_req(input int k, input logic [1:0] m, input logic [2:0] l,
                          input logic [31:0] a, input logic [31:0] w, input bit keep,
                          output logic [31:0] rd, output logic er, output int lat,
                          output bit stall_bad);
        rv[k] = 1'b1; mw[k] = m; ld[k] = l; ad[k] = a; wd[k] = w;
        lat = -1; stall_bad = 1'b0; rd = '0; er = 1'b0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge CLK);
            if (rdy[k] === 1'b1) begin
                lat = c; rd = rdat[k]; er = aerr[k];
                if (stl[k] !== 1'b0) stall_bad = 1'b1;
            end else if (stl[k] !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        @(posedge CLK); #1;
        if (!keep) rv[k] = 1'b0;
    endtask

    task automatic test_reset;
        int run [3];
        bit seen_rdy;
        logic [31:0] rd; logic er; int lat; bit sb;
        rv = '0; mw = '0; ld = '0; ad = '0; wd = '0;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        total++; if (rdy !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", rdy); end
        total++; if (aerr !== 3'b000) begin bad++; $display("FAIL reset_adderr got=%b want=000", aerr); end
        total++; if (rdat[1] !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdat[1]); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        run = '{0, 0, 0}; seen_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 3; i++) if (stl[i] === 1'b1 && run[i] == c) run[i]++;
            if (rdy !== 3'b000) seen_rdy = 1'b1;
        end
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (run[i] != 16) begin bad++; $display("FAIL sweep_stall_len[%0d] got=%0d want=16", i, run[i]); end
        end
        total++; if (seen_rdy) begin bad++; $display("FAIL sweep_ready got=1 want=0"); end
        do_req(1, 2'b00, 3'b000, 32'h3C, 32'h0, 1'b0, rd, er, lat, sb);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL clear_lw_3c got=%h want=00000000", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL clear_lw_err got=%b want=0", er); end
        total++; if (lat != 2) begin bad++; $display("FAIL clear_lw_lat got=%0d want=2", lat); end
    endtask

    task automatic test_store_load;
        logic [1:0]  m_t [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [2:0]  l_t [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100};
        logic [31:0] a_t [7] = '{32'h8, 32'hA, 32'h8, 32'h8, 32'hA, 32'hA, 32'h8};
        logic [31:0] w_t [7] = '{32'h11223344, 32'hAA, 32'hBEEF, 0, 0, 0, 0};
        logic [31:0] e_t [7] = '{0, 0, 0, 32'h11AABEEF, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFFBEEF};
        logic [31:0] rd; logic er; int lat; bit sb;
        for (int i = 0; i < 7; i++) begin
            do_req(1, m_t[i], l_t[i], a_t[i], w_t[i], 1'b0, rd, er, lat, sb);
            total++; if (rd !== e_t[i]) begin bad++; $display("FAIL mix_data[%0d] got=%h want=%h", i, rd, e_t[i]); end
            total++; if (er !== 1'b0) begin bad++; $display("FAIL mix_err[%0d] got=%b want=0", i, er); end
            total++; if (lat != 2) begin bad++; $display("FAIL mix_lat[%0d] got=%0d want=2", i, lat); end
            total++; if (sb) begin bad++; $display("FAIL mix_stall[%0d] got=bad want=ok", i); end
        end
        do_req(1, 2'b00, 3'b011, 32'hA, 32'h0, 1'b0, rd, er, lat, sb);
        total++; if (rd !== 32'h000011AA) begin bad++; $display("FAIL mix_lhu got=%h want=000011aa", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic er; int lat; bit sb; int p0;
        logic [31:0] exp_w;
        for (int k = 0; k < 3; k++) begin
            p0 = pc[k];
            for (int i = 0; i < 6; i++) begin
                exp_w = 32'hC0DE0000 + 32'(k * 16 + (i % 3));
                if (i < 3) do_req(k, 2'b01, 3'b000, 32'(16 + 4 * i), exp_w, 1'b1, rd, er, lat, sb);
                else       do_req(k, 2'b00, 3'b000, 32'(16 + 4 * (i - 3)), 32'h0, i != 5, rd, er, lat, sb);
                total++;
                if (lat != wc(k) + 1) begin bad++; $display("FAIL b2b_lat[w%0d,%0d] got=%0d want=%0d", wc(k), i, lat, wc(k) + 1); end
                total++;
                if (sb) begin bad++; $display("FAIL b2b_stall[w%0d,%0d] got=bad want=ok", wc(k), i); end
                total++;
                if (rd !== ((i < 3) ? 32'h0 : exp_w)) begin
                    bad++; $display("FAIL b2b_data[w%0d,%0d] got=%h want=%h", wc(k), i, rd, (i < 3) ? 32'h0 : exp_w);
                end
            end
            total++;
            if (pc[k] - p0 != 6) begin bad++; $display("FAIL b2b_pulses[w%0d] got=%0d want=6", wc(k), pc[k] - p0); end
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat; bit sb;
        do_req(1, 2'b01, 3'b000, 32'h0, 32'h12345678, 1'b0, rd, er, lat, sb);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL err_sw0 got=%b want=0", er); end
        do_req(1, 2'b01, 3'b000, 32'h2, 32'hFFFFFFFF, 1'b0, rd, er, lat, sb);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL err_sw_misal got=%b want=1", er); end
        total++; if (lat != 2) begin bad++; $display("FAIL err_sw_lat got=%0d want=2", lat); end
        do_req(1, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, rd, er, lat, sb);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL err_word_kept got=%h want=12345678", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL err_lw0 got=%b want=0", er); end
        do_req(1, 2'b00, 3'b100, 32'h1, 32'h0, 1'b0, rd, er, lat, sb);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL err_lh_misal got=%b want=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_lh_data got=%h want=00000000", rd); end
        do_req(1, 2'b00, 3'b000, 32'h40, 32'h0, 1'b0, rd, er, lat, sb);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL err_range got=%b want=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_range_data got=%h want=00000000", rd); end
    endtask

    task automatic test_stall_gating;
        logic [31:0] rd; logic er; int lat; bit sb;
        @(negedge CLK);
        total++; if (stl[1] !== 1'b0) begin bad++; $display("FAIL gate_idle got=%b want=0", stl[1]); end
        @(posedge CLK); #1;
        rv[1] = 1'b1; mw[1] = 2'b00; ld[1] = 3'b000; ad[1] = 32'h0;
        #2;
        total++; if (stl[1] !== 1'b1) begin bad++; $display("FAIL gate_raise got=%b want=1", stl[1]); end
        do_req(1, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, rd, er, lat, sb);
        total++; if (lat != 2) begin bad++; $display("FAIL gate_lat got=%0d want=2", lat); end
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL gate_data got=%h want=12345678", rd); end
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] rd; logic er; int lat; bit sb; int p0; int n; bit done;
        p0 = pc[2];
        rv[2] = 1'b1; mw[2] = 2'b01; ld[2] = 3'b000; ad[2] = 32'h4; wd[2] = 32'hDEADBEEF;
        @(posedge CLK);   // acceptance edge
        @(posedge CLK); #1; // now in the second BUSY cycle
        RESET = 1'b1; rv[2] = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        n = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (stl[2] === 1'b0) done = 1'b1;
            else n++;
        end
        @(posedge CLK); #1;
        total++; if (n != 16) begin bad++; $display("FAIL abort_sweep got=%0d want=16", n); end
        total++; if (pc[2] != p0) begin bad++; $display("FAIL abort_ready got=%0d want=0", pc[2] - p0); end
        do_req(2, 2'b00, 3'b000, 32'h4, 32'h0, 1'b0, rd, er, lat, sb);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL abort_data got=%h want=00000000", rd); end
        total++; if (lat != 4) begin bad++; $display("FAIL abort_lat got=%0d want=4", lat); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_stall_gating();
        test_reset_mid_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
